countdown_ctrl: RTL and testbench

Sequencing controller for the 9-to-0 BCD down-counter digit used in the counter designs. It divides the 50 MHz board clock into a 1 Hz count enable and owns the digit register. It runs a start/pause/done state machine with programmable reload and optional auto-reload. It sits between the board push-button/switch logic and the 7-segment display decoder.

---
 rtl/countdown_ctrl.sv | 141 ++++++++++++++
 tb/tb_countdown_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// Single-digit BCD countdown sequencer: divides clk into a count enable and
// runs the start/pause/done control for the displayed digit.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | stopped; digit and reload register can be loaded
// RUN   | prescaler advancing; digit decrements on each tick
// PAUSE | digit and prescaler frozen until the next pause pulse
// DONE  | countdown reached 0 without auto-reload; waits for start
module countdown_ctrl #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 1,
  parameter int START_VAL = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       load_en,
  input  logic [3:0] load_val,
  input  logic       auto_reload,
  output logic [3:0] q,
  output logic       tick,
  output logic       done,
  output logic       busy,
  output logic [1:0] state
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [3:0]    START_Q   = 4'(START_VAL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    q_q, q_d;
  logic [3:0]    reload_q, reload_d;
  logic          done_q, done_d;
  logic [3:0]    load_clamped;

  function automatic logic [3:0] clamp9(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  assign load_clamped = clamp9(load_val);
  assign tick         = (state_q == RUN) && (presc_q == PRESC_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      q_q      <= START_Q;
      reload_q <= START_Q;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    q_d      = q_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_en) begin
          reload_d = load_clamped;
          q_d      = load_clamped;
        end
        // a load on the same edge as start seeds the run with the new value
        if (start) begin
          state_d = RUN;
          presc_d = '0;
          q_d     = load_en ? load_clamped : reload_q;
        end
      end

      RUN: begin
        if (tick) begin
          presc_d = '0;
          if (q_q != 4'd0) begin
            q_d = q_q - 4'd1;
          end else if (auto_reload) begin
            q_d    = reload_q;
            done_d = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
        // reaching DONE outranks a coincident pause
        if (pause && (state_d == RUN)) begin
          state_d = PAUSE;
        end
      end

      PAUSE: begin
        if (pause) begin
          state_d = RUN;
        end
      end

      DONE: begin
        if (load_en) begin
          reload_d = load_clamped;
        end
        if (start) begin
          state_d = RUN;
          presc_d = '0;
          q_d     = reload_d;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign q     = q_q;
  assign done  = done_q;
  assign busy  = (state_q == RUN) || (state_q == PAUSE);
  assign state = state_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl with a 4-cycle count period.
module tb_countdown_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       load_en = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       auto_reload = 1'b0;
  logic [3:0] q;
  logic       tick;
  logic       done;
  logic       busy;
  logic [1:0] state;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  countdown_ctrl #(
    .CLK_HZ   (4),
    .TICK_HZ  (1),
    .START_VAL(9)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .load_en    (load_en),
    .load_val   (load_val),
    .auto_reload(auto_reload),
    .q          (q),
    .tick       (tick),
    .done       (done),
    .busy       (busy),
    .state      (state)
  );

  typedef struct {
    string      name;
    logic [3:0] q;
    logic [1:0] s;
    logic       tk;
    logic       dn;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       st;
    logic       pa;
    logic       ld;
    logic [3:0] lv;
    logic [3:0] q;
    logic [1:0] s;
    string      name;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[10];

  task automatic check_out();
    exp_t e;
    logic eb;
    n_assert++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: got no expectation queued, required one");
      return;
    end
    e  = sbq.pop_front();
    eb = (e.s == 2'd1) || (e.s == 2'd2);
    if ({q, state, tick, done, busy} !== {e.q, e.s, e.tk, e.dn, eb}) begin
      n_fail++;
      $display("FAIL %s: got q=%0d state=%0d tick=%0b done=%0b busy=%0b, required q=%0d state=%0d tick=%0b done=%0b busy=%0b",
               e.name, q, state, tick, done, busy, e.q, e.s, e.tk, e.dn, eb);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, check after the edge.
  task automatic cyc(input logic r, input logic s, input logic p, input logic l,
                     input logic [3:0] lv, input string nm, input logic [3:0] eq,
                     input logic [1:0] es, input logic et, input logic ed);
    exp_t e;
    reset    = r;
    start    = s;
    pause    = p;
    load_en  = l;
    load_val = lv;
    e.name = nm;
    e.q    = eq;
    e.s    = es;
    e.tk   = et;
    e.dn   = ed;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd9, 2'd0, "reset0"};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd9, 2'd0, "reset1"};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd9, 2'd0, "idle_pause_ignored"};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd12, 4'd9, 2'd0, "load12_clamped"};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3,  4'd3, 2'd0, "load3"};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  4'd0, 2'd0, "load0"};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd9,  4'd9, 2'd0, "load9_with_pause"};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd5,  4'd5, 2'd0, "load5"};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd9, 2'd0, "reset_drops_load"};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd9, 2'd0, "idle_hold"};

    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].rst, vecs[i].st, vecs[i].pa, vecs[i].ld, vecs[i].lv,
          vecs[i].name, vecs[i].q, vecs[i].s, 1'b0, 1'b0);
    end

    // full countdown from 9 to DONE
    auto_reload = 1'b0;
    cyc(0, 1, 0, 0, 4'd0, "full_start", 4'd9, 2'd1, 1'b0, 1'b0);
    for (int k = 1; k <= 44; k++) begin
      if (k < 40)
        cyc(0, 0, 0, 0, 4'd0, $sformatf("full_k%0d", k), 4'(9 - k / 4), 2'd1, (k % 4 == 3), 1'b0);
      else if (k == 40)
        cyc(0, 0, 0, 0, 4'd0, "full_done", 4'd0, 2'd3, 1'b0, 1'b1);
      else
        cyc(0, 0, 0, 0, 4'd0, $sformatf("done_hold_k%0d", k), 4'd0, 2'd3, 1'b0, 1'b0);
    end

    cyc(0, 0, 1, 0, 4'd0, "done_pause_ignored", 4'd0, 2'd3, 1'b0, 1'b0);
    cyc(0, 0, 0, 1, 4'd2, "done_load_keeps_q", 4'd0, 2'd3, 1'b0, 1'b0);

    // start+pause in DONE restarts from reload=2, with auto-reload on
    auto_reload = 1'b1;
    cyc(0, 1, 1, 0, 4'd0, "done_start_pause", 4'd2, 2'd1, 1'b0, 1'b0);
    for (int k = 1; k <= 25; k++) begin
      cyc(0, (k == 6), 0, (k == 5), 4'd7, $sformatf("auto_k%0d", k),
          4'(2 - ((k / 4) % 3)), 2'd1, (k % 4 == 3), (k % 12 == 0));
    end
    auto_reload = 1'b0;
    cyc(1, 0, 0, 0, 4'd0, "reset_after_auto", 4'd9, 2'd0, 1'b0, 1'b0);

    // pause two cycles after the first decrement, hold, then resume
    cyc(0, 1, 0, 0, 4'd0, "pr_start", 4'd9, 2'd1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 0, 0, 0, 4'd0, $sformatf("pr_k%0d", k), 4'(9 - k / 4), 2'd1, (k % 4 == 3), 1'b0);
    end
    cyc(0, 0, 1, 0, 4'd0, "pr_pause", 4'd8, 2'd2, 1'b0, 1'b0);
    for (int j = 1; j <= 20; j++) begin
      cyc(0, (j == 3), 0, (j == 7), 4'd1, $sformatf("pr_hold_j%0d", j), 4'd8, 2'd2, 1'b0, 1'b0);
    end
    cyc(0, 0, 1, 0, 4'd0, "pr_resume", 4'd8, 2'd1, 1'b0, 1'b0);
    for (int j = 1; j <= 6; j++) begin
      cyc(0, 0, 0, 0, 4'd0, $sformatf("pr_run_j%0d", j),
          (j < 2) ? 4'd8 : ((j < 6) ? 4'd7 : 4'd6), 2'd1, (j == 1 || j == 5), 1'b0);
    end

    // reset while paused at q=5
    cyc(1, 0, 0, 0, 4'd0, "mid_reset0", 4'd9, 2'd0, 1'b0, 1'b0);
    cyc(0, 0, 0, 1, 4'd5, "mid_load5", 4'd5, 2'd0, 1'b0, 1'b0);
    cyc(0, 1, 0, 0, 4'd0, "mid_start", 4'd5, 2'd1, 1'b0, 1'b0);
    cyc(0, 0, 1, 0, 4'd0, "mid_pause", 4'd5, 2'd2, 1'b0, 1'b0);
    cyc(1, 0, 0, 0, 4'd0, "mid_reset", 4'd9, 2'd0, 1'b0, 1'b0);
    cyc(0, 1, 0, 0, 4'd0, "mid_restart_reload9", 4'd9, 2'd1, 1'b0, 1'b0);

    // load 3 in IDLE then count to DONE
    cyc(1, 0, 0, 0, 4'd0, "l3_reset", 4'd9, 2'd0, 1'b0, 1'b0);
    cyc(0, 0, 0, 1, 4'd3, "l3_load", 4'd3, 2'd0, 1'b0, 1'b0);
    cyc(0, 1, 0, 0, 4'd0, "l3_start", 4'd3, 2'd1, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      if (k < 16)
        cyc(0, 0, 0, 0, 4'd0, $sformatf("l3_k%0d", k), 4'(3 - k / 4), 2'd1, (k % 4 == 3), 1'b0);
      else
        cyc(0, 0, 0, 0, 4'd0, "l3_done", 4'd0, 2'd3, 1'b0, 1'b1);
    end

    // start and load on the same edge in IDLE
    cyc(1, 0, 0, 0, 4'd0, "sl_reset", 4'd9, 2'd0, 1'b0, 1'b0);
    cyc(0, 1, 0, 1, 4'd4, "sl_start_load4", 4'd4, 2'd1, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 0, 0, 4'd0, $sformatf("sl_k%0d", k), 4'(4 - k / 4), 2'd1, (k % 4 == 3), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
